// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Purpose:
//   Writer side of the instruction ROM. Consumes a little-endian program image
//   from a byte stream (4-byte word count N, then N 4-byte words, LSB first),
//   writes each word into the ROM one cycle after its last byte arrives, and
//   holds the core in reset until the whole image has been accepted.
//
// Parameters:
//   ADDR_WIDTH    ROM byte-address width; capacity 2^(ADDR_WIDTH-2) words
//   BASE_ADDRESS  byte address of the first written word (multiple of 4)
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   rx_data        received byte
//   rx_valid       1-cycle strobe, rx_data valid; accepted unconditionally
//   rom_wren       ROM write enable, one pulse per word
//   rom_address    ROM byte address of the word being written (held otherwise)
//   rom_write_data word being written (held otherwise)
//   cpu_reset_n    core reset, 0 = core held in reset
//   load_done      image accepted, core released
//   load_error     image rejected, core stays in reset
//
// Build option:
//   LOADER_CHECKSUM_EN  when defined, the image is followed by a 4-byte
//                       checksum (sum of all words mod 2^32); the core is only
//                       released if it matches.
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned BASE_ADDRESS = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rom_wren,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic [31:0]           rom_write_data,
    output logic                  cpu_reset_n,
    output logic                  load_done,
    output logic                  load_error
);

    // Remaining-word counter must hold the full capacity 2^(ADDR_WIDTH-2).
    localparam int unsigned CNT_W = ADDR_WIDTH - 1;

    // Largest acceptable word count; computed wide so that huge N values
    // from the stream compare correctly without truncation.
    localparam logic [32:0] MAX_WORDS =
        33'((64'd1 << (ADDR_WIDTH - 2)) - 64'(BASE_ADDRESS / 4));

    localparam logic [ADDR_WIDTH-1:0] BASE_PTR = ADDR_WIDTH'(BASE_ADDRESS);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

    typedef enum logic [2:0] {
        RECV_COUNT,
        RECV_WORD,
`ifdef LOADER_CHECKSUM_EN
        RECV_SUM,
`endif
        DONE,
        ERROR
    } state_t;

    state_t                state;
    logic [1:0]            byte_idx;
    logic [23:0]           byte_buf;
    logic [CNT_W-1:0]      remaining;
    logic [ADDR_WIDTH-1:0] word_ptr;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]           sum;
`endif

    logic        receiving;
    logic        word_complete;
    logic [31:0] word;

    // The 4th byte is used straight from rx_data, so only three bytes are buffered.
    always_comb begin
        receiving = (state == RECV_COUNT) || (state == RECV_WORD);
`ifdef LOADER_CHECKSUM_EN
        receiving = receiving || (state == RECV_SUM);
`endif
        word_complete = receiving && rx_valid && (byte_idx == 2'd3);
        word          = {rx_data, byte_buf};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= RECV_COUNT;
            byte_idx       <= '0;
            byte_buf       <= '0;
            remaining      <= '0;
            word_ptr       <= '0;
            rom_wren       <= 1'b0;
            rom_address    <= '0;
            rom_write_data <= '0;
            cpu_reset_n    <= 1'b0;
            load_done      <= 1'b0;
            load_error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum            <= '0;
`endif
        end else begin
            rom_wren <= 1'b0;

            if (receiving && rx_valid) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0:    byte_buf[7:0]   <= rx_data;
                    2'd1:    byte_buf[15:8]  <= rx_data;
                    2'd2:    byte_buf[23:16] <= rx_data;
                    default: ;
                endcase
            end

            case (state)
                RECV_COUNT: begin
                    if (word_complete) begin
                        if (word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state <= RECV_SUM;
                            sum   <= '0;
`else
                            state       <= DONE;
                            load_done   <= 1'b1;
                            cpu_reset_n <= 1'b1;
`endif
                        end else if ({1'b0, word} > MAX_WORDS) begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end else begin
                            state     <= RECV_WORD;
                            remaining <= word[CNT_W-1:0];
                            word_ptr  <= BASE_PTR;
`ifdef LOADER_CHECKSUM_EN
                            sum       <= '0;
`endif
                        end
                    end
                end

                RECV_WORD: begin
                    if (word_complete) begin
                        rom_wren       <= 1'b1;
                        rom_address    <= word_ptr;
                        rom_write_data <= word;
                        // After the final word of a full ROM this wraps
                        // internally, but it is never presented again.
                        word_ptr       <= word_ptr + WORD_STEP;
                        remaining      <= remaining - 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        sum            <= sum + word;
`endif
                        if (remaining == CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                            state <= RECV_SUM;
`else
                            state       <= DONE;
                            load_done   <= 1'b1;
                            cpu_reset_n <= 1'b1;
`endif
                        end
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                RECV_SUM: begin
                    if (word_complete) begin
                        if (word == sum) begin
                            state       <= DONE;
                            load_done   <= 1'b1;
                            cpu_reset_n <= 1'b1;
                        end else begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end
                    end
                end
`endif

                // Terminal states: stream ignored until reset.
                DONE:    ;
                ERROR:   ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//
// Purpose:
//   Self-checking bench for program_loader (ADDR_WIDTH=12, BASE_ADDRESS=0).
//   A byte-stream reference model keeps every accepted byte in a queue and
//   derives the expected ROM writes and status flags from the image format.
//   Directed images come from a table; randomized images follow.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_program_loader;

    localparam int unsigned MAXW = 1024;   // 2^(12-2) words, base 0
`ifdef LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rom_wren;
    logic [11:0] rom_address;
    logic [31:0] rom_write_data;
    logic        cpu_reset_n;
    logic        load_done;
    logic        load_error;

    program_loader #(
        .ADDR_WIDTH  (12),
        .BASE_ADDRESS(0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rom_wren      (rom_wren),
        .rom_address   (rom_address),
        .rom_write_data(rom_write_data),
        .cpu_reset_n   (cpu_reset_n),
        .load_done     (load_done),
        .load_error    (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  acc[$];
    bit          m_done, m_err, m_wren;
    logic [31:0] m_addr, m_data, m_sum, m_n;
    int unsigned obs_writes;
    logic [11:0] obs_last;

    function automatic logic [31:0] word_at(input int unsigned off);
        return {acc[off+3], acc[off+2], acc[off+1], acc[off]};
    endfunction

    task automatic model_reset();
        acc.delete();
        m_done = 0; m_err = 0; m_wren = 0;
        m_addr = '0; m_data = '0; m_sum = '0; m_n = '0;
        obs_writes = 0; obs_last = '0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int unsigned k, idx;
        logic [31:0] w;
        m_wren = 0;
        if (m_done || m_err) return;
        acc.push_back(b);
        k = acc.size();
        if (k % 4 != 0) return;
        if (k == 4) begin
            m_n = word_at(0);
            if (m_n > MAXW) m_err = 1;
            else if (m_n == 0 && !CS) m_done = 1;
            return;
        end
        idx = k / 4 - 2;
        w = word_at(k - 4);
        if (idx < m_n) begin
            m_wren = 1;
            m_addr = idx * 4;
            m_data = w;
            m_sum  = m_sum + w;
            if (idx == m_n - 1 && !CS) m_done = 1;
        end else begin
            if (w == m_sum) m_done = 1;
            else m_err = 1;
        end
    endtask

    // One clock cycle: drive inputs, advance past the edge, compare all outputs.
    task automatic step(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
        if (v) model_byte(d);
        else   m_wren = 0;
        if (rom_wren === 1'b1) begin
            obs_writes++;
            obs_last = rom_address;
        end
        chk("rom_wren",       32'(rom_wren),    32'(m_wren));
        chk("rom_address",    32'(rom_address), m_addr);
        chk("rom_write_data", rom_write_data,   m_data);
        chk("load_done",      32'(load_done),   32'(m_done));
        chk("load_error",     32'(load_error),  32'(m_err));
        chk("cpu_reset_n",    32'(cpu_reset_n), 32'(m_done));
        rx_valid = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] b, input bit gaps);
        if (gaps && $urandom_range(0, 2) == 0) step(1'b0, 8'($urandom));
        step(1'b1, b);
    endtask

    task automatic put_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) put_byte(w[8*i +: 8], gaps);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        chk("rst_rom_wren",    32'(rom_wren),    32'd0);
        chk("rst_rom_address", 32'(rom_address), 32'd0);
        chk("rst_rom_data",    rom_write_data,   32'd0);
        chk("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        chk("rst_load_done",   32'(load_done),   32'd0);
        chk("rst_load_error",  32'(load_error),  32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct packed {
        logic [31:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          cs_ok;
        bit          gaps;
        bit          exp_done;
        bit          exp_err;
        int unsigned exp_writes;
        logic [11:0] exp_last;
    } vec_t;

    // Sends count, words (first two from the record), optional checksum,
    // then a few trailing bytes that must be ignored.
    task automatic send_image(input vec_t v);
        int unsigned nw;
        logic [31:0] w, sum;
        put_word(v.n, v.gaps);
        nw  = (v.n > MAXW) ? 4 : v.n;
        sum = '0;
        for (int unsigned i = 0; i < nw; i++) begin
            w = (i == 0) ? v.w0 : (i == 1) ? v.w1 : $urandom;
            sum = sum + w;
            put_word(w, v.gaps);
        end
        if (CS && v.n <= MAXW) put_word(v.cs_ok ? sum : sum + 32'd1, v.gaps);
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom));
    endtask

    task automatic final_check(input vec_t v, input string tag);
        chk({tag, "_done"},   32'(load_done),   32'(v.exp_done));
        chk({tag, "_error"},  32'(load_error),  32'(v.exp_err));
        chk({tag, "_cpu"},    32'(cpu_reset_n), 32'(v.exp_done));
        chk({tag, "_writes"}, obs_writes,       v.exp_writes);
        if (v.exp_writes > 0) chk({tag, "_last_addr"}, 32'(obs_last), 32'(v.exp_last));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        vec_t v;

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        model_reset();

        vecs.push_back('{32'd0,          32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 0,    12'h000});
        vecs.push_back('{32'd2,          32'h00500093, 32'h00A00113, 1'b1, 1'b0, 1'b1, 1'b0, 2,    12'h004});
        vecs.push_back('{32'd1025,       32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 0,    12'h000});
        vecs.push_back('{32'd1024,       32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 1'b1, 1'b0, 1024, 12'hFFC});
        vecs.push_back('{32'hFFFFFFFF,   32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 0,    12'h000});
        vecs.push_back('{32'h00010000,   32'h0,        32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 0,    12'h000});
        vecs.push_back('{32'd3,          32'hDEADBEEF, 32'h0BADF00D, 1'b1, 1'b1, 1'b1, 1'b0, 3,    12'h008});
        vecs.push_back('{32'd1,          32'hCAFEF00D, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1,    12'h000});
`ifdef LOADER_CHECKSUM_EN
        vecs.push_back('{32'd2,          32'd1,        32'd2,        1'b1, 1'b0, 1'b1, 1'b0, 2,    12'h004});
        vecs.push_back('{32'd2,          32'd1,        32'd2,        1'b0, 1'b0, 1'b0, 1'b1, 2,    12'h004});
        vecs.push_back('{32'd0,          32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 0,    12'h000});
`endif

        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            do_reset();
            send_image(vecs[i]);
            final_check(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset after 6 bytes of an N=3 image, then a fresh N=1 image.
        do_reset();
        put_word(32'd3, 1'b0);
        step(1'b1, 8'h44);
        step(1'b1, 8'h33);
        do_reset();
        v = '{32'd1, 32'h11223344, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 12'h000};
        send_image(v);
        final_check(v, "midreset6");

        // Reset after one word was already written: held data must clear.
        do_reset();
        put_word(32'd3, 1'b0);
        put_word(32'hA5A5A5A5, 1'b0);
        step(1'b1, 8'h01);
        step(1'b1, 8'h02);
        do_reset();
        v = '{32'd2, 32'h55667788, 32'h99AABBCC, 1'b1, 1'b1, 1'b1, 1'b0, 2, 12'h004};
        send_image(v);
        final_check(v, "midreset10");

        // Randomized images checked purely against the model.
        for (int it = 0; it < 30; it++) begin
            v.n     = ($urandom_range(0, 7) == 0) ? 32'(MAXW + $urandom_range(1, 5))
                                                  : 32'($urandom_range(0, 12));
            v.w0    = $urandom;
            v.w1    = $urandom;
            v.cs_ok = ($urandom_range(0, 3) != 0);
            v.gaps  = $urandom_range(0, 1) != 0;
            do_reset();
            send_image(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
